// File: rtl/addsub_8bit_reg_pkg.sv
// Shared constants for the add/subtract datapath unit.
package alu_pkg;
   localparam int ALU_WIDTH = 8;
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/addsub_8bit_reg_if.sv
// Operand/result bundle between the issuing stage and the add/sub unit.
interface addsub_8bit_reg_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             op;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             zero;
   logic             negative;

   modport master (
      output in_valid, a, b, op,
      input  out_valid, result, carry_out, overflow, zero, negative
   );
   modport slave (
      input  in_valid, a, b, op,
      output out_valid, result, carry_out, overflow, zero, negative
   );
endinterface

// File: rtl/addsub_8bit_reg_full_adder.sv
// One-bit full adder; a link in the ripple-carry chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/addsub_8bit_reg.sv
// Registered add/subtract unit: ripple-carry core, flags and result captured
// one cycle after the operands are presented.
module addsub_8bit_reg
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input logic clk,
   input logic rst,
   addsub_8bit_reg_if.slave bus
);
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum;
   logic [WIDTH:0]   carry;

   logic             out_valid_reg;
   logic [WIDTH-1:0] result_reg;
   logic             carry_out_reg;
   logic             overflow_reg;
   logic             zero_reg;
   logic             negative_reg;

   // Subtraction reuses the adder: invert b and inject a carry of one.
   assign b_eff    = bus.b ^ {WIDTH{bus.op}};
   assign carry[0] = (bus.op == OP_SUB);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
         full_adder u_fa (
            .a    (bus.a[gi]),
            .b    (b_eff[gi]),
            .cin  (carry[gi]),
            .sum  (sum[gi]),
            .cout (carry[gi+1])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         carry_out_reg <= 1'b0;
         overflow_reg  <= 1'b0;
         zero_reg      <= 1'b0;
         negative_reg  <= 1'b0;
      end else begin
         out_valid_reg <= bus.in_valid;
         // Idle cycles keep the last result and flags visible.
         if (bus.in_valid) begin
            result_reg    <= sum;
            carry_out_reg <= carry[WIDTH];
            overflow_reg  <= carry[WIDTH] ^ carry[WIDTH-1];
            zero_reg      <= (sum == '0);
            negative_reg  <= sum[WIDTH-1];
         end
      end
   end

   assign bus.out_valid = out_valid_reg;
   assign bus.result    = result_reg;
   assign bus.carry_out = carry_out_reg;
   assign bus.overflow  = overflow_reg;
   assign bus.zero      = zero_reg;
   assign bus.negative  = negative_reg;
endmodule

// File: tb/tb_addsub_8bit_reg.sv
// Scoreboard bench for addsub_8bit_reg: arithmetic reference model plus
// directed table cases and random vectors.
module tb_addsub_8bit_reg;
   logic clk;
   logic rst;

   addsub_8bit_reg_if #(.WIDTH(8)) bus ();

   addsub_8bit_reg #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [7:0] r;
      logic       c;
      logic       o;
      logic       z;
      logic       n;
   } exp_t;

   exp_t q[$];
   exp_t model;
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one cycle, push the model's prediction, compare after the edge.
   task automatic step(input logic r, input logic v, input logic [7:0] av,
                       input logic [7:0] bv, input logic o);
      exp_t e;
      int   sa, sb, sres;
      rst          = r;
      bus.in_valid = v;
      bus.a        = av;
      bus.b        = bv;
      bus.op       = o;
      if (r) begin
         model = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      end else begin
         model.v = v;
         if (v) begin
            sa = $signed(av);
            sb = $signed(bv);
            if (o) begin
               model.r = av - bv;
               model.c = (av >= bv);
               sres    = sa - sb;
            end else begin
               model.r = av + bv;
               model.c = (int'(av) + int'(bv)) > 255;
               sres    = sa + sb;
            end
            model.o = (sres > 127) || (sres < -128);
            model.z = (model.r == 8'd0);
            model.n = model.r[7];
         end
      end
      q.push_back(model);
      @(posedge clk);
      #1;
      e = q.pop_front();
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, e.v});
      check("result",    {24'd0, bus.result},    {24'd0, e.r});
      check("carry",     {31'd0, bus.carry_out}, {31'd0, e.c});
      check("overflow",  {31'd0, bus.overflow},  {31'd0, e.o});
      check("zero",      {31'd0, bus.zero},      {31'd0, e.z});
      check("negative",  {31'd0, bus.negative},  {31'd0, e.n});
      $display("txn rst=%0b v=%0b a=%0d b=%0d op=%0b -> ov=%0b res=%0d c=%0b o=%0b z=%0b n=%0b",
               r, v, av, bv, o, bus.out_valid, bus.result, bus.carry_out,
               bus.overflow, bus.zero, bus.negative);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       op;
      logic [7:0] r;
      logic       c;
      logic       o;
      logic       n;
   } vec_t;

   vec_t tbl[16] = '{
      '{8'd15,  8'd8,   1'b0, 8'd23,  1'b0, 1'b0, 1'b0},
      '{8'd15,  8'd8,   1'b1, 8'd7,   1'b1, 1'b0, 1'b0},
      '{8'd1,   8'd2,   1'b1, 8'd255, 1'b0, 1'b0, 1'b1},
      '{8'd170, 8'd85,  1'b0, 8'd255, 1'b0, 1'b0, 1'b1},
      '{8'd170, 8'd85,  1'b1, 8'd85,  1'b1, 1'b1, 1'b0},
      '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0, 1'b0},
      '{8'd255, 8'd1,   1'b1, 8'd254, 1'b1, 1'b0, 1'b1},
      '{8'd0,   8'd255, 1'b0, 8'd255, 1'b0, 1'b0, 1'b1},
      '{8'd0,   8'd255, 1'b1, 8'd1,   1'b0, 1'b0, 1'b0},
      '{8'd100, 8'd100, 1'b0, 8'd200, 1'b0, 1'b1, 1'b1},
      '{8'd120, 8'd11,  1'b0, 8'd131, 1'b0, 1'b1, 1'b1},
      '{8'd7,   8'd128, 1'b1, 8'd135, 1'b0, 1'b1, 1'b1},
      '{8'd42,  8'd101, 1'b0, 8'd143, 1'b0, 1'b1, 1'b1},
      '{8'd42,  8'd101, 1'b1, 8'd197, 1'b0, 1'b0, 1'b1},
      '{8'd7,   8'd128, 1'b0, 8'd135, 1'b0, 1'b0, 1'b1},
      '{8'd100, 8'd100, 1'b1, 8'd0,   1'b1, 1'b0, 1'b0}
   };

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      bus.op       = 1'b0;
      model        = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset with a valid op presented: discarded, all outputs zero.
      step(1'b1, 1'b1, 8'd5, 8'd3, 1'b0);
      step(1'b1, 1'b1, 8'd5, 8'd3, 1'b0);
      check("reset_result", {24'd0, bus.result}, 32'd0);
      step(1'b0, 1'b1, 8'd1, 8'd2, 1'b0);
      check("first_op", {24'd0, bus.result}, 32'd3);

      // Directed table: fixed expected values alongside the model.
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].op);
         check("tbl_result", {24'd0, bus.result},    {24'd0, tbl[i].r});
         check("tbl_carry",  {31'd0, bus.carry_out}, {31'd0, tbl[i].c});
         check("tbl_ovf",    {31'd0, bus.overflow},  {31'd0, tbl[i].o});
         check("tbl_neg",    {31'd0, bus.negative},  {31'd0, tbl[i].n});
      end

      // Hold: idle cycle after 100-100 keeps zero result and flags.
      step(1'b0, 1'b0, 8'd9, 8'd9, 1'b0);
      check("hold_valid",  {31'd0, bus.out_valid}, 32'd0);
      check("hold_result", {24'd0, bus.result},    32'd0);
      check("hold_zero",   {31'd0, bus.zero},      32'd1);
      check("hold_carry",  {31'd0, bus.carry_out}, 32'd1);

      // Back-to-back alternating add/sub.
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 8'd120, 8'd11, i[0]);
         check("b2b_result", {24'd0, bus.result}, i[0] ? 32'd109 : 32'd131);
         check("b2b_valid",  {31'd0, bus.out_valid}, 32'd1);
      end

      // Reset mid-stream discards the concurrent op.
      step(1'b1, 1'b1, 8'd50, 8'd60, 1'b0);
      check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst_result", {24'd0, bus.result}, 32'd0);

      for (int i = 0; i < 1000; i++) begin
         step(1'b0, ($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom),
              1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
